// File: rtl/pps_pulse_generator_if.sv
// Configuration and status bundle for pps_pulse_generator.
// PPS_PULSE_GEN_COUNT_EN adds the o_pulse_count status field.
interface pps_pulse_generator_if #(
    parameter int CNT_W = 32
);
    logic             i_enable;
    logic             i_load;
    logic [CNT_W-1:0] i_cfg_delay;
    logic [CNT_W-1:0] i_cfg_width;
    logic [CNT_W-1:0] i_cfg_period;
    logic             o_pulse;
    logic             o_busy;
    logic             o_cfg_err;
`ifdef PPS_PULSE_GEN_COUNT_EN
    logic [15:0]      o_pulse_count;

    modport master (
        output i_enable, i_load, i_cfg_delay, i_cfg_width, i_cfg_period,
        input  o_pulse, o_busy, o_cfg_err, o_pulse_count
    );
    modport slave (
        input  i_enable, i_load, i_cfg_delay, i_cfg_width, i_cfg_period,
        output o_pulse, o_busy, o_cfg_err, o_pulse_count
    );
`else
    modport master (
        output i_enable, i_load, i_cfg_delay, i_cfg_width, i_cfg_period,
        input  o_pulse, o_busy, o_cfg_err
    );
    modport slave (
        input  i_enable, i_load, i_cfg_delay, i_cfg_width, i_cfg_period,
        output o_pulse, o_busy, o_cfg_err
    );
`endif
endinterface

// File: rtl/pps_pulse_generator.sv
// PPS-aligned programmable pulse train with double-buffered configuration.
// Optional macro PPS_PULSE_GEN_COUNT_EN adds a per-second pulse counter.
module pps_pulse_generator #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_pps,
    pps_pulse_generator_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_HIGH,
        ST_LOW
    } state_t;

    state_t                 state_reg, state_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   pps_d_reg;
    logic                   pps_rise_reg;
    logic [CNT_W-1:0]       shd_delay_reg, shd_width_reg, shd_period_reg;
    logic [CNT_W-1:0]       act_delay_reg, act_width_reg, act_period_reg;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   act_loaded_reg;
    logic                   cfg_err_reg;
    logic                   pulse_reg, pulse_next;
    logic [CNT_W-1:0]       sel_delay, sel_width, sel_period;
    logic                   sel_valid;

    function automatic logic cfg_ok(input logic [CNT_W-1:0] width,
                                    input logic [CNT_W-1:0] period);
        return (period >= CNT_TWO) && (width != '0) && (width < period);
    endfunction

    // Synchroniser (SYNC_STAGES >= 2) followed by a registered edge detector
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_reg     <= '0;
            pps_d_reg    <= 1'b0;
            pps_rise_reg <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], i_pps};
            pps_d_reg    <= sync_reg[SYNC_STAGES-1];
            pps_rise_reg <= sync_reg[SYNC_STAGES-1] & ~pps_d_reg;
        end
    end

    // On a PPS the FSM starts from the shadow values that are being copied
    // into active this same edge, so the new second uses them immediately.
    assign sel_delay  = pps_rise_reg ? shd_delay_reg  : act_delay_reg;
    assign sel_width  = pps_rise_reg ? shd_width_reg  : act_width_reg;
    assign sel_period = pps_rise_reg ? shd_period_reg : act_period_reg;
    assign sel_valid  = cfg_ok(sel_width, sel_period);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shd_delay_reg  <= '0;
            shd_width_reg  <= '0;
            shd_period_reg <= '0;
            act_delay_reg  <= '0;
            act_width_reg  <= '0;
            act_period_reg <= '0;
            act_loaded_reg <= 1'b0;
            cfg_err_reg    <= 1'b0;
        end else begin
            if (bus.i_load) begin
                shd_delay_reg  <= bus.i_cfg_delay;
                shd_width_reg  <= bus.i_cfg_width;
                shd_period_reg <= bus.i_cfg_period;
            end
            if (pps_rise_reg) begin
                act_delay_reg  <= shd_delay_reg;
                act_width_reg  <= shd_width_reg;
                act_period_reg <= shd_period_reg;
                act_loaded_reg <= 1'b1;
            end
            // Cleared-at-reset active values are not reported until a copy happens
            cfg_err_reg <= act_loaded_reg & ~cfg_ok(act_width_reg, act_period_reg);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            pulse_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pulse_reg <= pulse_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pulse_next = 1'b0;
        if (!bus.i_enable) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else if (pps_rise_reg && state_reg != ST_IDLE) begin
            // Re-align: any pulse in flight is cut short at this edge
            if (!sel_valid) begin
                state_next = ST_ARMED;
                cnt_next   = '0;
            end else if (sel_delay == '0) begin
                state_next = ST_HIGH;
                cnt_next   = sel_width - CNT_ONE;
            end else begin
                state_next = ST_DELAY;
                cnt_next   = sel_delay - CNT_ONE;
            end
        end else begin
            case (state_reg)
                ST_IDLE:  state_next = ST_ARMED;
                ST_ARMED: state_next = ST_ARMED;
                ST_DELAY: begin
                    if (cnt_reg == '0) begin
                        state_next = ST_HIGH;
                        cnt_next   = sel_width - CNT_ONE;
                    end else begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    pulse_next = 1'b1;
                    if (cnt_reg == '0) begin
                        state_next = ST_LOW;
                        cnt_next   = sel_period - sel_width - CNT_ONE;
                    end else begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                end
                ST_LOW: begin
                    if (cnt_reg == '0) begin
                        state_next = ST_HIGH;
                        cnt_next   = sel_width - CNT_ONE;
                    end else begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign bus.o_pulse   = pulse_reg;
    assign bus.o_busy    = (state_reg == ST_DELAY) || (state_reg == ST_HIGH) ||
                           (state_reg == ST_LOW);
    assign bus.o_cfg_err = cfg_err_reg;

`ifdef PPS_PULSE_GEN_COUNT_EN
    logic [15:0] pulse_count_reg;
    logic        pulse_rise;

    assign pulse_rise = pulse_next & ~pulse_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pulse_count_reg <= '0;
        end else if (pps_rise_reg) begin
            pulse_count_reg <= {15'd0, pulse_rise};
        end else if (pulse_rise && pulse_count_reg != 16'hFFFF) begin
            pulse_count_reg <= pulse_count_reg + 16'd1;
        end
    end

    assign bus.o_pulse_count = pulse_count_reg;
`endif

endmodule

// File: tb/tb_pps_pulse_generator.sv
// Directed self-checking bench for pps_pulse_generator; edge k is the first
// clock edge that samples i_pps high, outputs are sampled 1 ns after edges.
module tb_pps_pulse_generator;

    logic clk;
    logic rst_n;
    logic pps;
    int   n_checks;
    int   n_fail;

    pps_pulse_generator_if #(.CNT_W(32)) bus_if ();

    pps_pulse_generator #(
        .CNT_W       (32),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_pps   (pps),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", tag, got, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [31:0] d, input logic [31:0] w, input logic [31:0] p);
        bus_if.i_cfg_delay  = d;
        bus_if.i_cfg_width  = w;
        bus_if.i_cfg_period = p;
        bus_if.i_load       = 1'b1;
        step(1);
        bus_if.i_load       = 1'b0;
    endtask

    // Returns just after edge k
    task automatic pps_edge();
        pps = 1'b1;
        step(1);
        pps = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        pps      = 1'b0;
        bus_if.i_enable     = 1'b0;
        bus_if.i_load       = 1'b0;
        bus_if.i_cfg_delay  = '0;
        bus_if.i_cfg_width  = '0;
        bus_if.i_cfg_period = '0;
        step(3);
        check("reset_pulse", {31'd0, bus_if.o_pulse}, 32'd0);
        check("reset_busy", {31'd0, bus_if.o_busy}, 32'd0);
        check("reset_cfg_err", {31'd0, bus_if.o_cfg_err}, 32'd0);
        rst_n = 1'b1;
        step(2);

        // Basic train: first PPS only copies (still IDLE), second PPS starts it
        load_cfg(32'd0, 32'd3, 32'd10);
        pps_edge();
        step(6);
        check("copy_only_pulse", {31'd0, bus_if.o_pulse}, 32'd0);
        check("copy_only_err", {31'd0, bus_if.o_cfg_err}, 32'd0);
        bus_if.i_enable = 1'b1;
        step(10);
        check("armed_busy", {31'd0, bus_if.o_busy}, 32'd0);
        check("armed_pulse", {31'd0, bus_if.o_pulse}, 32'd0);
        pps_edge();
        step(3);
        check("basic_k3", {31'd0, bus_if.o_pulse}, 32'd0);
        step(1);
        check("basic_k4", {31'd0, bus_if.o_pulse}, 32'd1);
        check("basic_busy", {31'd0, bus_if.o_busy}, 32'd1);
        step(2);
        check("basic_k6", {31'd0, bus_if.o_pulse}, 32'd1);
        step(1);
        check("basic_k7", {31'd0, bus_if.o_pulse}, 32'd0);
        step(6);
        check("basic_k13", {31'd0, bus_if.o_pulse}, 32'd0);
        step(1);
        check("basic_k14", {31'd0, bus_if.o_pulse}, 32'd1);

        // Delay 5, width 2, period 8: train starts at k+9
        load_cfg(32'd5, 32'd2, 32'd8);
        pps_edge();
        step(8);
        check("delay_k8", {31'd0, bus_if.o_pulse}, 32'd0);
        step(1);
        check("delay_k9", {31'd0, bus_if.o_pulse}, 32'd1);
        step(1);
        check("delay_k10", {31'd0, bus_if.o_pulse}, 32'd1);
        step(1);
        check("delay_k11", {31'd0, bus_if.o_pulse}, 32'd0);
        step(38);
        pps_edge();
        step(8);
        check("realign50_k8", {31'd0, bus_if.o_pulse}, 32'd0);
        step(1);
        check("realign50_k9", {31'd0, bus_if.o_pulse}, 32'd1);
        // Next PPS 47 cycles later lands on the first cycle of a pulse
        step(37);
        pps_edge();
        step(2);
        check("trunc_k2", {31'd0, bus_if.o_pulse}, 32'd1);
        step(1);
        check("trunc_k3", {31'd0, bus_if.o_pulse}, 32'd0);
        step(6);
        check("trunc_k9", {31'd0, bus_if.o_pulse}, 32'd1);

        // Load coinciding with pps_rise: this second keeps width 2
        step(20);
        pps_edge();
        step(2);
        bus_if.i_cfg_delay  = 32'd5;
        bus_if.i_cfg_width  = 32'd4;
        bus_if.i_cfg_period = 32'd8;
        bus_if.i_load       = 1'b1;
        step(1);
        bus_if.i_load       = 1'b0;
        step(6);
        check("coll_k9", {31'd0, bus_if.o_pulse}, 32'd1);
        step(2);
        check("coll_k11_w2", {31'd0, bus_if.o_pulse}, 32'd0);
        step(38);
        pps_edge();
        step(11);
        check("coll_next_k11_w4", {31'd0, bus_if.o_pulse}, 32'd1);
        step(2);
        check("coll_next_k13", {31'd0, bus_if.o_pulse}, 32'd0);

        // Invalid configuration width == period
        load_cfg(32'd0, 32'd10, 32'd10);
        pps_edge();
        step(4);
        check("inv_err", {31'd0, bus_if.o_cfg_err}, 32'd1);
        check("inv_busy", {31'd0, bus_if.o_busy}, 32'd0);
        check("inv_pulse_k4", {31'd0, bus_if.o_pulse}, 32'd0);
        step(10);
        check("inv_pulse_k14", {31'd0, bus_if.o_pulse}, 32'd0);
        load_cfg(32'd0, 32'd5, 32'd10);
        pps_edge();
        step(4);
        check("fix_err", {31'd0, bus_if.o_cfg_err}, 32'd0);
        check("fix_pulse_k4", {31'd0, bus_if.o_pulse}, 32'd1);

        // Enable drop: IDLE next edge, shadow retained
        bus_if.i_enable = 1'b0;
        step(1);
        check("dis_pulse", {31'd0, bus_if.o_pulse}, 32'd0);
        check("dis_busy", {31'd0, bus_if.o_busy}, 32'd0);
        bus_if.i_enable = 1'b1;
        step(5);
        check("reen_pulse", {31'd0, bus_if.o_pulse}, 32'd0);
        check("reen_busy", {31'd0, bus_if.o_busy}, 32'd0);
        pps_edge();
        step(4);
        check("reen_k4", {31'd0, bus_if.o_pulse}, 32'd1);
        step(4);
        check("reen_k8", {31'd0, bus_if.o_pulse}, 32'd1);
        step(1);
        check("reen_k9", {31'd0, bus_if.o_pulse}, 32'd0);

        // Asynchronous reset during HIGH
        step(5);
        check("pre_rst_k14", {31'd0, bus_if.o_pulse}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_pulse", {31'd0, bus_if.o_pulse}, 32'd0);
        check("rst_async_busy", {31'd0, bus_if.o_busy}, 32'd0);
        step(2);
        rst_n = 1'b1;
        step(20);
        check("post_rst_pulse", {31'd0, bus_if.o_pulse}, 32'd0);
        check("post_rst_busy", {31'd0, bus_if.o_busy}, 32'd0);
        check("post_rst_err", {31'd0, bus_if.o_cfg_err}, 32'd0);
        pps_edge();
        step(4);
        check("rst_cleared_pulse", {31'd0, bus_if.o_pulse}, 32'd0);
        step(1);
        check("rst_cleared_err", {31'd0, bus_if.o_cfg_err}, 32'd1);
        load_cfg(32'd0, 32'd3, 32'd10);
        pps_edge();
        step(4);
        check("restart_k4", {31'd0, bus_if.o_pulse}, 32'd1);

`ifdef PPS_PULSE_GEN_COUNT_EN
        // Count: 10 rising edges in a 40-cycle second, then 1 after re-align
        load_cfg(32'd0, 32'd1, 32'd4);
        pps_edge();
        step(39);
        pps_edge();
        step(2);
        check("count_before", {16'd0, bus_if.o_pulse_count}, 32'd10);
        step(2);
        check("count_after", {16'd0, bus_if.o_pulse_count}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
